// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / hazard unit: the in-flight
// destination tag record, the register-file select code and the select width.
package fwd_pkg;

    // Widest register address a tag can hold; narrower addresses are zero-extended.
    localparam int TAG_RD_W = 8;

    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                wr_en;
        logic                is_load;
    } fwd_tag_t;

    function automatic int sel_w(input int fwd_stages);
        return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage view of the forwarding unit: operand/destination info in,
// bypass selects and stall request out.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int SEL_W      = sel_w(2)
);
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]            id_rs_used;
    logic [REG_ADDR_W-1:0]         id_rd;
    logic                          id_wr_en;
    logic                          id_is_load;
    logic                          flush;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_is_load, flush,
        input  fwd_sel, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_is_load, flush,
        output fwd_sel, stall
    );
endinterface

// File: rtl/fwd_src_match.sv
// One ID source operand against the shadow tag pipeline: youngest-producer
// bypass select plus a flag for a load result that is not yet forwardable.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W       = 4,
    parameter int FWD_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int R0_IS_ZERO       = 1,
    parameter int SEL_W            = sel_w(FWD_STAGES)
) (
    input  logic                        id_valid,
    input  logic [REG_ADDR_W-1:0]       rs,
    input  logic                        rs_used,
    input  fwd_tag_t [FWD_STAGES:1]     tags,
    output logic [SEL_W-1:0]            sel,
    output logic                        load_hazard
);

    logic                rs_live;
    logic [TAG_RD_W-1:0] rs_ext;

    assign rs_ext  = TAG_RD_W'(rs);
    assign rs_live = id_valid && rs_used && !((R0_IS_ZERO != 0) && (rs == '0));

    // Walk oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        sel         = SEL_W'(SEL_RF);
        load_hazard = 1'b0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (rs_live && tags[k].valid && tags[k].wr_en && (tags[k].rd == rs_ext)) begin
                sel         = SEL_W'(k);
                load_hazard = tags[k].is_load && (k < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with a shadow tag pipeline for EX..WB.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W       = 4,
    parameter int NUM_SRC          = 2,
    parameter int FWD_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int R0_IS_ZERO       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
`ifdef FWD_PERF_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       stall_count,
    output logic [15:0]       fwd_count
`endif
);

    localparam int SEL_W = sel_w(FWD_STAGES);

    fwd_tag_t [FWD_STAGES:1]    tags;
    logic [SEL_W-1:0]           src_sel [NUM_SRC];
    logic [NUM_SRC-1:0]         src_hazard;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel_flat;
    logic                       stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W       (REG_ADDR_W),
            .FWD_STAGES       (FWD_STAGES),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .R0_IS_ZERO       (R0_IS_ZERO),
            .SEL_W            (SEL_W)
        ) u_match (
            .id_valid    (bus.id_valid),
            .rs          (bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .rs_used     (bus.id_rs_used[i]),
            .tags        (tags),
            .sel         (src_sel[i]),
            .load_hazard (src_hazard[i])
        );
    end

    always_comb begin
        fwd_sel_flat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel_flat[i*SEL_W +: SEL_W] = src_sel[i];
        end
    end

    // A flushed ID instruction is dead, so it can never need to wait.
    assign stall       = (|src_hazard) && !bus.flush;
    assign bus.stall   = stall;
    assign bus.fwd_sel = fwd_sel_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only the valid bits matter, but clearing whole tags keeps bubbles all-zero.
            tags <= '0;
        end else begin
            // NOTE: non-blocking, so each stage takes its predecessor's pre-edge value.
            if (bus.id_valid && !stall && !bus.flush) begin
                tags[1] <= '{valid:   1'b1,
                             rd:      TAG_RD_W'(bus.id_rd),
                             wr_en:   bus.id_wr_en,
                             is_load: bus.id_is_load};
            end else begin
                tags[1] <= '0;
            end
            for (int k = 2; k <= FWD_STAGES; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic any_fwd;
    assign any_fwd = |fwd_sel_flat;

    // Saturating counters; a clear in the same cycle as an event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (any_fwd && (fwd_count != 16'hFFFF)) begin
                fwd_count <= fwd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed, table-driven bench for fwd_hazard_unit in its default configuration;
// the counter sequences are compiled in when FWD_PERF_CNT_EN is defined.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_SRC    = 2;
    localparam int FWD_STAGES = 2;
    localparam int SEL_W      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

`ifdef FWD_PERF_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] stall_count;
    logic [15:0] fwd_count;
`endif

    fwd_hazard_unit #(
        .REG_ADDR_W       (REG_ADDR_W),
        .NUM_SRC          (NUM_SRC),
        .FWD_STAGES       (FWD_STAGES),
        .LOAD_READY_STAGE (2),
        .R0_IS_ZERO       (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef FWD_PERF_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .stall_count (stall_count),
        .fwd_count   (fwd_count)
`endif
    );

    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] rs0;
        logic [3:0] rs1;
        logic [1:0] used;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       fl;
        logic [1:0] e_sel0;
        logic [1:0] e_sel1;
        logic       e_stall;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic valid, input logic [3:0] rs0,
                                input logic [3:0] rs1, input logic [1:0] used, input logic [3:0] rd,
                                input logic wr, input logic ld, input logic fl,
                                input logic [1:0] s0, input logic [1:0] s1, input logic st);
        vec_t v;
        v.name = name; v.valid = valid; v.rs0 = rs0; v.rs1 = rs1; v.used = used;
        v.rd = rd; v.wr = wr; v.ld = ld; v.fl = fl;
        v.e_sel0 = s0; v.e_sel1 = s1; v.e_stall = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_valid   = v.valid;
        bus.id_rs      = {v.rs1, v.rs0};
        bus.id_rs_used = v.used;
        bus.id_rd      = v.rd;
        bus.id_wr_en   = v.wr;
        bus.id_is_load = v.ld;
        bus.flush      = v.fl;
    endtask

    task automatic expect_out(input vec_t v);
        check({v.name, ".sel0"}, 32'(bus.fwd_sel[1:0]), 32'(v.e_sel0));
        check({v.name, ".sel1"}, 32'(bus.fwd_sel[3:2]), 32'(v.e_sel1));
        check({v.name, ".stall"}, 32'(bus.stall), 32'(v.e_stall));
    endtask

    // One ID cycle: drive just after the edge, compare on the falling edge.
    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        expect_out(v);
    endtask

    initial begin
        vec_t v;

        //            name                       val rs0 rs1 used  rd wr ld fl  s0 s1 st
        vecs.push_back(mk("add_r3",              1,  1,  2, 2'b11, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sub_rs1_r3",          1,  3,  7, 2'b11, 6, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("two_src_two_stages",  1,  6,  3, 2'b11, 0, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mk("stage2_only",         1,  6,  3, 2'b11, 8, 1, 0, 0, 2, 0, 0));
        vecs.push_back(mk("id_invalid",          0,  8,  8, 2'b11, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("add_r3_again",        1,  0,  0, 2'b00, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nop",                 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rs2_from_wb",         1,  3,  3, 2'b10, 3, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk("after_two_nops",      1,  3,  3, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("no_wr_no_match",      1,  3,  0, 2'b01, 5, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("load_use_stall",      1,  5,  0, 2'b01, 9, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk("load_use_release",    1,  5,  0, 2'b01, 9, 1, 0, 0, 2, 0, 0));
        vecs.push_back(mk("add_r4",              1,  9,  0, 2'b01, 4, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("load_r4",             1,  0,  9, 2'b10, 4, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk("youngest_load_wins",  1,  4,  4, 2'b11, 10, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk("youngest_release",    1,  4,  4, 2'b11, 10, 1, 0, 0, 2, 2, 0));
        vecs.push_back(mk("add_r0",              1,  0,  0, 2'b00, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("read_r0",             1,  0, 10, 2'b11, 5, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk("flush_over_stall",    1,  5,  0, 2'b01, 11, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk("flush_left_bubble",   1, 11,  5, 2'b11, 0, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk("load_r0_no_stall",    1,  0,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0));

        // Reset: a read-only instruction that could never match anyway.
        v = mk("in_reset", 1, 3, 3, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        @(negedge clk);
        expect_out(v);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        v.name = "first_after_reset";
        expect_out(v);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted in the middle of a load-use stall.
        run_vec(mk("mid_load_r5",   1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0));
        run_vec(mk("mid_stall",     1, 5, 0, 2'b01, 0, 0, 0, 0, 1, 0, 1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset.stall", 32'(bus.stall), 32'd0);
        check("async_reset.sel",   32'(bus.fwd_sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_async.stall", 32'(bus.stall), 32'd0);
        check("post_async.sel",   32'(bus.fwd_sel), 32'd0);

`ifdef FWD_PERF_CNT_EN
        cnt_clr = 1'b1;
        run_vec(mk("cnt_idle0", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        cnt_clr = 1'b0;
        check("cnt_after_clr.stall", 32'(stall_count), 32'd0);
        check("cnt_after_clr.fwd",   32'(fwd_count),   32'd0);
        for (int n = 0; n < 3; n++) begin
            run_vec(mk("cnt_load",    1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0));
            run_vec(mk("cnt_stall",   1, 5, 0, 2'b01, 0, 0, 0, 0, 1, 0, 1));
            run_vec(mk("cnt_release", 1, 5, 0, 2'b01, 0, 0, 0, 0, 2, 0, 0));
        end
        run_vec(mk("cnt_idle1", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        check("cnt_three_stalls", 32'(stall_count), 32'd3);
        check("cnt_six_fwds",     32'(fwd_count),   32'd6);

        run_vec(mk("cnt_add_r5a", 1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0));
        run_vec(mk("cnt_add_r5b", 1, 5, 0, 2'b01, 5, 1, 0, 0, 1, 0, 0));
        cnt_clr = 1'b1;
        run_vec(mk("cnt_add_r5c", 1, 5, 0, 2'b01, 5, 1, 0, 0, 1, 0, 0));
        cnt_clr = 1'b0;
        check("clr_beats_inc.fwd",   32'(fwd_count),   32'd0);
        check("clr_beats_inc.stall", 32'(stall_count), 32'd0);

        // Back-to-back dependent ALU ops forward every cycle.
        repeat (65545) @(posedge clk);
        @(negedge clk);
        check("fwd_saturates",    32'(fwd_count),   32'hFFFF);
        check("no_stalls_counted", 32'(stall_count), 32'd0);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("sat_clr.fwd",   32'(fwd_count),   32'd0);
        check("sat_clr.stall", 32'(stall_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
